axi_wr_initiator: RTL

Write-channel initiator that drives the AW/W channels of an AXI3-style slave and accepts out-of-order B responses. It takes one burst command at a time from a local command port, streams its data beats from a local data port, and tracks one outstanding transaction per ID. Each B response is returned on a registered completion port. It sits opposite the out-of-order write responder and is the bench-side and system-side driver for it.

---
 rtl/axi_pkg.sv | 30 +++
 rtl/axi_id_tracker.sv | 57 +++++
 rtl/axi_wr_initiator.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI write-path definitions.
// Holds the burst/response/FSM enumerations and the default bus widths used by
// both the write initiator and the out-of-order write responder.
package axi_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 2;
  localparam int AXI_LEN_W  = 8;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } wr_state_e;

endpackage

// File: rtl/axi_id_tracker.sv
// Per-ID outstanding tracker for the write initiator.
// Ports:
//   set_en/set_id    mark an ID busy (command accepted)
//   clr_en/clr_id    a B response arrived for clr_id
//   hold_en/hold_id  ID whose burst is still being issued; a B for it is
//                    premature and must not free the ID
//   busy             registered busy vector, one bit per ID
//   count            registered popcount of busy
//   clr_unexp        combinational: the current clear is for a non-busy or
//                    still-issuing ID (the clear is then ignored)
module axi_id_tracker
  import axi_pkg::*;
#(
  parameter int ID_W = AXI_ID_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [ID_W-1:0]      set_id,
  input  logic                 clr_en,
  input  logic [ID_W-1:0]      clr_id,
  input  logic                 hold_en,
  input  logic [ID_W-1:0]      hold_id,
  output logic [2**ID_W-1:0]   busy,
  output logic [ID_W:0]        count,
  output logic                 clr_unexp
);

  localparam int N = 2**ID_W;

  logic [N-1:0]  busy_next;
  logic [ID_W:0] count_next;

  always_comb begin
    clr_unexp  = clr_en && (!busy[clr_id] || (hold_en && (hold_id == clr_id)));
    busy_next  = busy;
    if (clr_en && !clr_unexp) busy_next[clr_id] = 1'b0;
    // A set and a valid clear never target the same ID: the command side only
    // accepts IDs that are not busy, and a clear of a non-busy ID is ignored.
    if (set_en) busy_next[set_id] = 1'b1;
    count_next = '0;
    for (int i = 0; i < N; i++) begin
      count_next = count_next + {{ID_W{1'b0}}, busy_next[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= '0;
      count <= '0;
    end else begin
      busy  <= busy_next;
      count <= count_next;
    end
  end

endmodule

// File: rtl/axi_wr_initiator.sv
// AXI3-style write initiator: one burst command at a time on AW/W, any number
// of out-of-order B responses (one outstanding burst per ID).
// Ports:
//   cmd_*        local burst command (addr, id, len, size, burst)
//   wr_*         local data beats, passed straight to W during the data phase
//   aw*/w*/b*    AXI write address, data and response channels
//   cpl_*        registered completion (id, resp) for every accepted B
//   outstanding  registered number of busy IDs
//   err_unexp_b  sticky flag: a B arrived for an ID that was not awaiting one
//   fsm_state    current issue-FSM state, for observation
// Handshake rule on every channel: a transfer happens on a rising clk edge
// where valid && ready; a source that raises valid holds it and its payload
// unchanged until that transfer; ready may depend combinationally on valid.
module axi_wr_initiator
  import axi_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W,
  parameter int ID_W   = AXI_ID_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [ID_W-1:0]     cmd_id,
  input  logic [7:0]          cmd_len,
  input  logic [2:0]          cmd_size,
  input  logic [1:0]          cmd_burst,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [ID_W-1:0]     awid,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic [ID_W-1:0]     wid,
  output logic                wlast,
  input  logic                bvalid,
  output logic                bready,
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  output logic                cpl_valid,
  input  logic                cpl_ready,
  output logic [ID_W-1:0]     cpl_id,
  output logic [1:0]          cpl_resp,
  output logic [ID_W:0]       outstanding,
  output logic                err_unexp_b,
  output wr_state_e           fsm_state
);

  wr_state_e           state_q, state_d;
  logic [7:0]          beat_cnt_q;
  logic [2**ID_W-1:0]  busy;
  logic                cmd_hs, aw_hs, w_hs, b_hs, b_unexp;

  assign cmd_hs    = cmd_valid && cmd_ready;
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign b_hs      = bvalid && bready;
  assign bready    = !cpl_valid || cpl_ready;
  assign fsm_state = state_q;

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    wr_ready  = 1'b0;
    wdata     = '0;
    wstrb     = '0;
    wid       = '0;
    wlast     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Uses the registered busy bit, so a B freeing this ID in the same
        // cycle only lets the command in on the following cycle.
        cmd_ready = rst_n && !busy[cmd_id];
        if (cmd_valid && cmd_ready) state_d = ADDR;
      end
      ADDR: begin
        awvalid = 1'b1;
        if (awready) state_d = DATA;
      end
      DATA: begin
        wvalid   = wr_valid;
        wr_ready = wready;
        wdata    = wr_data;
        wstrb    = wr_strb;
        wid      = awid;
        wlast    = (beat_cnt_q == awlen);
        if (wr_valid && wready && wlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      awaddr     <= '0;
      awid       <= '0;
      awlen      <= '0;
      awsize     <= '0;
      awburst    <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_hs) begin
        awaddr  <= cmd_addr;
        awid    <= cmd_id;
        awlen   <= cmd_len;
        awsize  <= cmd_size;
        awburst <= cmd_burst;
      end
      if (aw_hs) beat_cnt_q <= '0;
      else if (w_hs) beat_cnt_q <= beat_cnt_q + 8'd1;
    end
  end

  // Completion register: bready guarantees it is empty or draining when a new
  // B is captured, so nothing is overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpl_valid   <= 1'b0;
      cpl_id      <= '0;
      cpl_resp    <= '0;
      err_unexp_b <= 1'b0;
    end else begin
      if (b_hs) begin
        cpl_valid <= 1'b1;
        cpl_id    <= bid;
        cpl_resp  <= bresp;
      end else if (cpl_ready) begin
        cpl_valid <= 1'b0;
      end
      if (b_hs && b_unexp) err_unexp_b <= 1'b1;
    end
  end

  // The burst still being issued (ADDR or DATA) is protected: a B for its ID
  // is premature, reported as unexpected, and does not free the ID.
  axi_id_tracker #(.ID_W(ID_W)) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (cmd_hs),
    .set_id    (cmd_id),
    .clr_en    (b_hs),
    .clr_id    (bid),
    .hold_en   (state_q != IDLE),
    .hold_id   (awid),
    .busy      (busy),
    .count     (outstanding),
    .clr_unexp (b_unexp)
  );

endmodule
